// File: rtl/riscv_pkg.sv
// riscv_pkg: types shared between the core datapath and the M-extension sequencer.
//   alu_op_e    - 4-bit opcode of the core's shared ALU (encoding owned by the ALU).
//   md_funct3_e - RV32M funct3 selector for multiply/divide instructions.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_funct3_e;

endpackage

// File: rtl/md_negate.sv
// md_negate: combinational conditional two's-complement negate.
//   neg_i - 1: res_o = -val_i, 0: res_o = val_i
//   val_i - W-bit input value
//   res_o - W-bit result
module md_negate #(
    parameter int W = 64
) (
    input  logic         neg_i,
    input  logic [W-1:0] val_i,
    output logic [W-1:0] res_o
);

    assign res_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer that borrows the
// core's shared ALU for its per-bit add / compare / subtract.
//   i_clk, i_reset          - clock, asynchronous active-high reset
//   i_valid/o_ready         - request handshake; i_funct3, i_rs1, i_rs2 sampled on accept
//   i_flush                 - abort any in-flight operation, back to IDLE
//   o_valid/i_res_ready     - result handshake; o_result holds rd
//   o_alu_sel               - sequencer owns the ALU (core stalls)
//   o_alu_op_a/b, o_alu_op  - ALU operands and opcode
//   i_alu_data              - ALU result, combinational in the same cycle
module muldiv_seq
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_res_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_alu_sel,
    output logic [XLEN-1:0] o_alu_op_a,
    output logic [XLEN-1:0] o_alu_op_b,
    output logic [3:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_PREP, S_ITER_A, S_ITER_B, S_FIX, S_DONE
    } state_e;

    // hi_q/lo_q: {acc_hi, multiplier} for MUL*, {remainder, quotient} for DIV*.
    // mcand_q: multiplicand / divisor. sum_q: ITER_A ALU result (sum or lt flag).
    state_e           state_q, state_d;
    md_funct3_e       funct3_q, funct3_d;
    logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d, sum_q, sum_d;
    logic [XLEN-1:0]  result_q, result_d, alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic             ext_q, ext_d, neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_op_e          alu_op_q, alu_op_d;
    logic             ready_q, valid_q, alu_sel_q;

    logic is_div, is_rem, mul_hi, neg_a, neg_b;
    assign is_div = funct3_q inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    assign is_rem = funct3_q inside {MD_REM, MD_REMU};
    assign mul_hi = funct3_q inside {MD_MULH, MD_MULHSU, MD_MULHU};
    // In PREP lo_q holds raw rs1 and mcand_q holds raw rs2.
    assign neg_a  = (funct3_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && lo_q[XLEN-1];
    assign neg_b  = (funct3_q inside {MD_MULH, MD_DIV, MD_REM}) && mcand_q[XLEN-1];

    // Wide negator: abs(rs1) in PREP, final sign fix of product / q / rem in FIX.
    logic [2*XLEN-1:0] wide_in, wide_out;
    logic              wide_neg;
    logic [XLEN-1:0]   abs_b;
    assign wide_neg = (state_q == S_FIX) ? neg_q : neg_a;
    assign wide_in  = (state_q != S_FIX) ? {{XLEN{1'b0}}, lo_q} :
                      !is_div            ? {hi_q, lo_q} :
                                           {{XLEN{1'b0}}, is_rem ? hi_q : lo_q};

    md_negate #(.W(2*XLEN)) u_neg_wide (.neg_i(wide_neg), .val_i(wide_in), .res_o(wide_out));
    md_negate #(.W(XLEN))   u_neg_rs2  (.neg_i(neg_b),    .val_i(mcand_q), .res_o(abs_b));

    logic            go_iter, mul_c;
    logic [XLEN-1:0] base_hi, base_lo, mul_acc;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        sum_d    = sum_q;
        result_d = result_q;
        ext_d    = ext_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        alu_a_d  = '0;
        alu_b_d  = '0;
        alu_op_d = ALU_ADD;
        go_iter  = 1'b0;
        base_hi  = hi_q;
        base_lo  = lo_q;
        mul_c    = 1'b0;
        mul_acc  = hi_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    funct3_d = md_funct3_e'(i_funct3);
                    lo_d     = i_rs1;
                    mcand_d  = i_rs2;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                cnt_d = '0;
                ext_d = 1'b0;
                neg_d = is_rem ? neg_a : (neg_a ^ neg_b);
                if (is_div && mcand_q == '0) begin
                    // Divide by zero: preload q=all-ones, rem=raw rs1, and let FIX
                    // pick the right one without any sign correction.
                    hi_d    = lo_q;
                    lo_d    = '1;
                    neg_d   = 1'b0;
                    state_d = S_FIX;
                end else begin
                    mcand_d = abs_b;
                    base_hi = '0;
                    base_lo = wide_out[XLEN-1:0];
                    go_iter = 1'b1;
                end
            end
            S_ITER_A: begin
                sum_d    = i_alu_data;
                state_d  = S_ITER_B;
                alu_a_d  = is_div ? hi_q : i_alu_data;
                alu_b_d  = mcand_q;
                alu_op_d = is_div ? ALU_SUB : ALU_SLTU;
            end
            S_ITER_B: begin
                if (is_div) begin
                    // Restoring step: subtract when the shifted-out bit is set or rem >= dvsr.
                    if (ext_q || !sum_q[0]) begin
                        base_hi = i_alu_data;
                        base_lo = {lo_q[XLEN-1:1], 1'b1};
                    end
                end else begin
                    // sum < mcand after ADD means the add carried out.
                    if (lo_q[0]) begin
                        mul_acc = sum_q;
                        mul_c   = i_alu_data[0];
                    end
                    base_hi = {mul_c, mul_acc[XLEN-1:1]};
                    base_lo = {mul_acc[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(XLEN-1)) begin
                    hi_d    = base_hi;
                    lo_d    = base_lo;
                    state_d = S_FIX;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    go_iter = 1'b1;
                end
            end
            S_FIX: begin
                result_d = mul_hi ? wide_out[2*XLEN-1:XLEN] : wide_out[XLEN-1:0];
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (i_res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Entering ITER_A: divide shifts {rhi,rem,q} left; ALU operands are
        // registered, so they are prepared from the next-state values here.
        if (go_iter) begin
            state_d = S_ITER_A;
            if (is_div) begin
                {ext_d, hi_d, lo_d} = {base_hi, base_lo, 1'b0};
                alu_a_d  = {base_hi[XLEN-2:0], base_lo[XLEN-1]};
                alu_op_d = ALU_SLTU;
            end else begin
                hi_d     = base_hi;
                lo_d     = base_lo;
                alu_a_d  = base_hi;
                alu_op_d = ALU_ADD;
            end
            alu_b_d = mcand_d;
        end

        if (i_flush) begin
            state_d  = S_IDLE;
            result_d = '0;
            cnt_d    = '0;
            alu_a_d  = '0;
            alu_b_d  = '0;
            alu_op_d = ALU_ADD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the next-state
    // logic above uses blocking ones so later statements see earlier results.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            funct3_q  <= MD_MUL;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            sum_q     <= '0;
            result_q  <= '0;
            ext_q     <= 1'b0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_ADD;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            alu_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            sum_q     <= sum_d;
            result_q  <= result_d;
            ext_q     <= ext_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            ready_q   <= (state_d == S_IDLE);
            valid_q   <= (state_d == S_DONE);
            alu_sel_q <= (state_d == S_ITER_A) || (state_d == S_ITER_B);
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_result   = result_q;
    assign o_alu_sel  = alu_sel_q;
    assign o_alu_op_a = alu_a_q;
    assign o_alu_op_b = alu_b_q;
    assign o_alu_op   = alu_op_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural model of
// the shared ALU (ADD/SUB/SLTU). Stimulus pushes expected rd values; a
// monitor pops and compares whenever the DUT hands over a result.
module tb_muldiv_seq;
    import riscv_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset, i_valid, i_flush, i_res_ready;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1, i_rs2, i_alu_data;
    logic        o_ready, o_valid, o_alu_sel;
    logic [31:0] o_result, o_alu_op_a, o_alu_op_b;
    logic [3:0]  o_alu_op;

    always #5 i_clk = ~i_clk;

    muldiv_seq dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_flush(i_flush),
        .o_valid(o_valid), .i_res_ready(i_res_ready), .o_result(o_result),
        .o_alu_sel(o_alu_sel), .o_alu_op_a(o_alu_op_a), .o_alu_op_b(o_alu_op_b),
        .o_alu_op(o_alu_op), .i_alu_data(i_alu_data)
    );

    // Shared ALU model
    always_comb begin
        i_alu_data = '0;
        case (o_alu_op)
            4'd0:    i_alu_data = o_alu_op_a + o_alu_op_b;
            4'd1:    i_alu_data = o_alu_op_a - o_alu_op_b;
            4'd3:    i_alu_data = {31'b0, o_alu_op_a < o_alu_op_b};
            default: i_alu_data = '0;
        endcase
    end

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every handed-over result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (!i_reset && o_valid && i_res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected result: got 0x%08h with no request outstanding", o_result);
                end else begin
                    e = exp_q.pop_front();
                    check(e.name, o_result, e.value);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string name);
        int waited = 0;
        while (!o_ready && waited < 100) begin
            @(posedge i_clk); #1;
            waited++;
        end
        check({name, " o_ready"}, {31'b0, o_ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        i_valid  = 1'b1;
        i_funct3 = f3;
        i_rs1    = a;
        i_rs2    = b;
        @(posedge i_clk); #1;
        // Operands must be sampled on accept only.
        i_valid = 1'b0;
        i_rs1   = 32'hDEAD_BEEF;
        i_rs2   = 32'h0BAD_F00D;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int exp_sel, input int hold);
        int edges, sel, unstable;
        wait_ready(name);
        if (hold > 0) i_res_ready = 1'b0;
        exp_q.push_back(exp_t'{name: name, value: exp});
        issue(f3, a, b);
        edges = 0;
        sel   = 0;
        while (!o_valid && edges < 200) begin
            if (o_alu_sel) sel++;
            @(posedge i_clk); #1;
            edges++;
        end
        check({name, " latency"}, edges, exp_lat);
        check({name, " alu_sel cycles"}, sel, exp_sel);
        if (hold > 0) begin
            unstable = 0;
            repeat (hold) begin
                @(posedge i_clk); #1;
                if (o_result !== exp || o_ready !== 1'b0 || o_valid !== 1'b1) unstable++;
            end
            check({name, " hold stable"}, unstable, 0);
            i_res_ready = 1'b1;
        end
    endtask

    initial begin
        int cnt;
        i_reset     = 1'b1;
        i_valid     = 1'b0;
        i_flush     = 1'b0;
        i_res_ready = 1'b1;
        i_funct3    = '0;
        i_rs1       = '0;
        i_rs2       = '0;

        @(negedge i_clk);
        check("reset o_ready",   {31'b0, o_ready},   32'd1);
        check("reset o_valid",   {31'b0, o_valid},   32'd0);
        check("reset o_result",  o_result,           32'd0);
        check("reset o_alu_sel", {31'b0, o_alu_sel}, 32'd0);
        check("reset o_alu_op_a", o_alu_op_a,        32'd0);
        check("reset o_alu_op_b", o_alu_op_b,        32'd0);
        check("reset o_alu_op",  {28'b0, o_alu_op},  32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        run_op("MUL 7*-3",          3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 66, 64, 0);
        run_op("MULH min*min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 66, 64, 0);
        run_op("MULHU max*max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 66, 64, 0);
        run_op("MULHSU -1*max",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66, 64, 0);
        run_op("MULH -7*3",         3'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 66, 64, 0);
        run_op("MULHU 7*3",         3'd3, 32'd7,         32'd3,         32'd0,         66, 64, 0);
        run_op("DIV -7/2",          3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 66, 64, 0);
        run_op("REM -7/2",          3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 66, 64, 0);
        run_op("DIVU 100/7",        3'd5, 32'd100,       32'd7,         32'd14,        66, 64, 0);
        run_op("REMU 100/7",        3'd7, 32'd100,       32'd7,         32'd2,         66, 64, 0);
        run_op("DIV min/-1",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 66, 64, 0);
        run_op("REM min/-1",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         66, 64, 0);
        run_op("DIV 1234/0",        3'd4, 32'd1234,      32'd0,         32'hFFFF_FFFF, 2,  0,  0);
        run_op("REM 1234/0",        3'd6, 32'd1234,      32'd0,         32'd1234,      2,  0,  0);
        run_op("REMU -7/0",         3'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2,  0,  0);
        run_op("DIVU 100/7 held",   3'd5, 32'd100,       32'd7,         32'd14,        66, 64, 10);

        // Asynchronous reset in the middle of an iteration.
        wait_ready("async reset");
        issue(3'd0, 32'd5, 32'd5);
        repeat (10) begin @(posedge i_clk); #1; end
        check("pre-reset o_alu_sel", {31'b0, o_alu_sel}, 32'd1);
        #2 i_reset = 1'b1;
        #1;
        check("async reset o_ready",    {31'b0, o_ready},   32'd1);
        check("async reset o_valid",    {31'b0, o_valid},   32'd0);
        check("async reset o_result",   o_result,           32'd0);
        check("async reset o_alu_sel",  {31'b0, o_alu_sel}, 32'd0);
        check("async reset o_alu_op_a", o_alu_op_a,         32'd0);
        check("async reset o_alu_op_b", o_alu_op_b,         32'd0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;

        // Flush during iteration cycle 20: back to IDLE, no result ever.
        wait_ready("flush");
        issue(3'd0, 32'd9, 32'd9);
        repeat (20) begin @(posedge i_clk); #1; end
        check("pre-flush o_alu_sel", {31'b0, o_alu_sel}, 32'd1);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        check("flush o_ready",   {31'b0, o_ready},   32'd1);
        check("flush o_alu_sel", {31'b0, o_alu_sel}, 32'd0);
        cnt = 0;
        repeat (80) begin
            @(posedge i_clk); #1;
            if (o_valid) cnt++;
        end
        check("flush no o_valid", cnt, 0);

        run_op("DIVU after flush",  3'd5, 32'd100,       32'd7,         32'd14,        66, 64, 0);

        repeat (3) @(posedge i_clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
